// File: rtl/mxu_feed_ctrl_if.sv
// rtl/mxu_feed_ctrl_if.sv - LSU<->MXU feed controller signal bundle
// master = feed controller, slave = job source / operand buffers / MXU / writeback.
interface mxu_feed_ctrl_if #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 10,
    parameter int K_W    = 8
);
    localparam int PW = LANES * 8;
    localparam int RW = $clog2(LANES);

    logic              job_vld;
    logic              job_rdy;
    logic [K_W-1:0]    job_k;
    logic [ADDR_W-1:0] job_ibase;
    logic [ADDR_W-1:0] job_wbase;
    logic              job_clr;
    logic              job_pool_en;
    logic [1:0]        job_pool_size;
    logic              job_act_en;
    logic [1:0]        job_act_type;
    logic              job_i16;

    logic              ibuf_rd_en;
    logic [ADDR_W-1:0] ibuf_rd_addr;
    logic [PW-1:0]     ibuf_rd_data;
    logic              wbuf_rd_en;
    logic [ADDR_W-1:0] wbuf_rd_addr;
    logic [PW-1:0]     wbuf_rd_data;

    logic              lsu_mxu_vld;
    logic              lsu_mxu_clr;
    logic [LANES-1:0]  lsu_mxu_iram_vld;
    logic [PW-1:0]     lsu_mxu_iram_pld;
    logic [LANES-1:0]  lsu_mxu_wram_vld;
    logic [PW-1:0]     lsu_mxu_wram_pld;
    logic              lsu_mxu_pool_vld;
    logic [1:0]        lsu_mxu_pool_size;
    logic              lsu_mxu_act_vld;
    logic [1:0]        lsu_mxu_act_type;
    logic              lsu_mxu_wfi;
    logic              mxu_lsu_rdy;
    logic              mxu_lsu_data_rdy;
    logic [PW-1:0]     mxu_lsu_int8_row_data  [LANES];
    logic [2*PW-1:0]   mxu_lsu_int16_row_data [LANES];

    logic              res_vld;
    logic              res_rdy;
    logic [RW-1:0]     res_row;
    logic [2*PW-1:0]   res_data;
    logic              job_done;

    modport master (
        input  job_vld, job_k, job_ibase, job_wbase, job_clr, job_pool_en, job_pool_size,
               job_act_en, job_act_type, job_i16,
        output job_rdy,
        output ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
        input  ibuf_rd_data, wbuf_rd_data,
        output lsu_mxu_vld, lsu_mxu_clr, lsu_mxu_iram_vld, lsu_mxu_iram_pld,
               lsu_mxu_wram_vld, lsu_mxu_wram_pld, lsu_mxu_pool_vld, lsu_mxu_pool_size,
               lsu_mxu_act_vld, lsu_mxu_act_type, lsu_mxu_wfi,
        input  mxu_lsu_rdy, mxu_lsu_data_rdy, mxu_lsu_int8_row_data, mxu_lsu_int16_row_data,
        output res_vld, res_row, res_data, job_done,
        input  res_rdy
    );

    modport slave (
        output job_vld, job_k, job_ibase, job_wbase, job_clr, job_pool_en, job_pool_size,
               job_act_en, job_act_type, job_i16,
        input  job_rdy,
        input  ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
        output ibuf_rd_data, wbuf_rd_data,
        input  lsu_mxu_vld, lsu_mxu_clr, lsu_mxu_iram_vld, lsu_mxu_iram_pld,
               lsu_mxu_wram_vld, lsu_mxu_wram_pld, lsu_mxu_pool_vld, lsu_mxu_pool_size,
               lsu_mxu_act_vld, lsu_mxu_act_type, lsu_mxu_wfi,
        output mxu_lsu_rdy, mxu_lsu_data_rdy, mxu_lsu_int8_row_data, mxu_lsu_int16_row_data,
        input  res_vld, res_row, res_data, job_done,
        output res_rdy
    );
endinterface

// File: rtl/mxu_feed_ctrl.sv
// rtl/mxu_feed_ctrl.sv - LSU-side MXU job driver: clear/start, skewed operand feed, pool/act, row drain
// Optional MXU_FEED_PERF_EN adds perf_cycles (job accept..job_done cycle count, saturating).
module mxu_feed_ctrl #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 10,
    parameter int K_W    = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef MXU_FEED_PERF_EN
    output logic [31:0] perf_cycles,
`endif
    mxu_feed_ctrl_if.master bus
);
    localparam int PW = LANES * 8;
    localparam int RW = $clog2(LANES);
    localparam int FW = K_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_CMD, S_FEED, S_POST, S_WAIT, S_DRAIN
    } state_t;

    state_t            r_state, w_next;
    logic [K_W-1:0]    r_k;
    logic [ADDR_W-1:0] r_ibase, r_wbase;
    logic              r_pool_en, r_act_en, r_i16;
    logic [1:0]        r_pool_size, r_act_type;
    logic [FW-1:0]     r_fc;
    logic [RW-1:0]     r_row;
    logic              r_rd_vld;

    logic w_accept, w_rd, w_feed_last, w_row_last, w_post, w_drain;

    assign w_accept    = (r_state == S_IDLE) && bus.job_vld;
    assign w_rd        = (r_state == S_FEED) && (r_fc < FW'(r_k));
    // FEED covers K reads plus LANES-1 extra cycles to flush the deepest skew lane.
    assign w_feed_last = (r_fc == FW'(r_k) + FW'(LANES - 1));
    assign w_row_last  = (r_row == RW'(LANES - 1));
    assign w_post      = (r_state == S_POST);
    assign w_drain     = (r_state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_ibase     <= '0;
            r_wbase     <= '0;
            r_pool_en   <= 1'b0;
            r_pool_size <= '0;
            r_act_en    <= 1'b0;
            r_act_type  <= '0;
            r_i16       <= 1'b0;
            r_fc        <= '0;
            r_row       <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rd_vld <= w_rd;
            if (w_accept) begin
                r_k         <= bus.job_k;
                r_ibase     <= bus.job_ibase;
                r_wbase     <= bus.job_wbase;
                r_pool_en   <= bus.job_pool_en;
                r_pool_size <= bus.job_pool_size;
                r_act_en    <= bus.job_act_en;
                r_act_type  <= bus.job_act_type;
                r_i16       <= bus.job_i16;
            end
            if (r_state == S_FEED) r_fc <= r_fc + FW'(1);
            else                   r_fc <= '0;
            if (w_drain && bus.res_rdy) r_row <= w_row_last ? '0 : r_row + RW'(1);
            else if (!w_drain)          r_row <= '0;
        end
    end

    always_comb begin
        w_next                = r_state;
        bus.job_rdy           = (r_state == S_IDLE);
        bus.lsu_mxu_clr       = (r_state == S_CLR);
        bus.lsu_mxu_vld       = (r_state == S_CMD);
        bus.ibuf_rd_en        = w_rd;
        bus.wbuf_rd_en        = w_rd;
        bus.ibuf_rd_addr      = w_rd ? r_ibase + ADDR_W'(r_fc) : '0;
        bus.wbuf_rd_addr      = w_rd ? r_wbase + ADDR_W'(r_fc) : '0;
        bus.lsu_mxu_pool_vld  = w_post && r_pool_en;
        bus.lsu_mxu_pool_size = w_post ? r_pool_size : '0;
        bus.lsu_mxu_act_vld   = w_post && r_act_en;
        bus.lsu_mxu_act_type  = w_post ? r_act_type : '0;
        bus.lsu_mxu_wfi       = (r_state == S_WAIT);
        bus.res_vld           = w_drain;
        bus.res_row           = w_drain ? r_row : '0;
        bus.res_data          = '0;
        bus.job_done          = w_drain && bus.res_rdy && w_row_last;
        if (w_drain) begin
            bus.res_data = r_i16 ? bus.mxu_lsu_int16_row_data[r_row]
                                 : {{PW{1'b0}}, bus.mxu_lsu_int8_row_data[r_row]};
        end
        case (r_state)
            S_IDLE:  if (bus.job_vld) w_next = bus.job_clr ? S_CLR : S_CMD;
            S_CLR:   w_next = S_CMD;
            S_CMD:   if (bus.mxu_lsu_rdy) w_next = (r_k == '0) ? S_POST : S_FEED;
            S_FEED:  if (w_feed_last) w_next = S_POST;
            S_POST:  w_next = S_WAIT;
            S_WAIT:  if (bus.mxu_lsu_data_rdy) w_next = S_DRAIN;
            S_DRAIN: if (bus.res_rdy && w_row_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane i sees byte i of the vector returned i cycles earlier; lane 0 is the buffer output itself.
    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic       w_v;
        logic [7:0] w_ib, w_wb;
        if (gi == 0) begin : g_direct
            assign w_v  = r_rd_vld;
            assign w_ib = bus.ibuf_rd_data[7:0];
            assign w_wb = bus.wbuf_rd_data[7:0];
        end else begin : g_delay
            logic [16:0] r_dl [gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) r_dl[d] <= '0;
                end else begin
                    r_dl[0] <= {r_rd_vld, bus.ibuf_rd_data[gi*8 +: 8], bus.wbuf_rd_data[gi*8 +: 8]};
                    for (int d = 1; d < gi; d++) r_dl[d] <= r_dl[d-1];
                end
            end
            assign {w_v, w_ib, w_wb} = r_dl[gi-1];
        end
        assign bus.lsu_mxu_iram_vld[gi]       = w_v;
        assign bus.lsu_mxu_wram_vld[gi]       = w_v;
        assign bus.lsu_mxu_iram_pld[gi*8 +: 8] = w_v ? w_ib : 8'h00;
        assign bus.lsu_mxu_wram_pld[gi*8 +: 8] = w_v ? w_wb : 8'h00;
    end

`ifdef MXU_FEED_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            r_perf <= '0;
        else if (w_accept)                                  r_perf <= 32'd1;
        else if (r_state != S_IDLE && r_perf != 32'hFFFF_FFFF) r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`endif
endmodule
